// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types for the forwarding/hazard unit: in-flight destination tag and
// bypass-select helpers.
package hazard_pkg;

  // Bypass select value meaning "take the register file".
  localparam int FWD_RF = 0;

  // Tag dst is stored at a fixed width; REG_AW up to this value is supported.
  localparam int TAG_DST_W = 8;

  typedef struct packed {
    logic                 v;
    logic [TAG_DST_W-1:0] dst;
    logic                 ld;
  } hazard_tag_t;

  // Bypass select k refers to tag[k-1]; returns -1 for the register file.
  function automatic int sel_to_stage(input int sel);
    return sel - 1;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage decode fields in, bypass selects / stall out.
interface fwd_hazard_unit_if #(
  parameter int REG_AW  = 3,
  parameter int NUM_FWD = 3,
  parameter int CNT_W   = 16
);
  import hazard_pkg::*;

  localparam int SEL_W = $clog2(NUM_FWD + 1);

  logic              id_valid;
  logic [REG_AW-1:0] id_src_a;
  logic              id_use_a;
  logic [REG_AW-1:0] id_src_b;
  logic              id_use_b;
  logic [REG_AW-1:0] id_dst;
  logic              id_wr;
  logic              id_load;
  logic              flush;
  logic [SEL_W-1:0]  fwd_sel_a;
  logic [SEL_W-1:0]  fwd_sel_b;
  logic              stall;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_src_a, id_use_a, id_src_b, id_use_b,
           id_dst, id_wr, id_load, flush,
    input  fwd_sel_a, fwd_sel_b, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_src_a, id_use_a, id_src_b, id_use_b,
           id_dst, id_wr, id_load, flush,
    output fwd_sel_a, fwd_sel_b, stall, stall_cnt
  );

endinterface

// File: rtl/fwd_hazard_unit_prio_match.sv
// Youngest-first priority match of one source operand against the in-flight tags.
module fwd_prio_match
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 3,
  parameter int NUM_FWD    = 3,
  parameter int LOAD_STAGE = 1,
  parameter int SEL_W      = $clog2(NUM_FWD + 1)
) (
  input  hazard_tag_t [NUM_FWD-1:0] tags,
  input  logic [REG_AW-1:0]         src,
  input  logic                      use_src,
  output logic [SEL_W-1:0]          sel,
  output logic                      load_hazard
);

  logic [NUM_FWD-1:0] hit;

  generate
    for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_hit
      assign hit[gi] = use_src & tags[gi].v & (tags[gi].dst == TAG_DST_W'(src));
    end
  endgenerate

  // Scan oldest to youngest so the youngest hit is the last to assign.
  always_comb begin
    sel         = SEL_W'(FWD_RF);
    load_hazard = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (hit[i]) begin
        if (tags[i].ld && (i < LOAD_STAGE)) begin
          sel         = SEL_W'(FWD_RF);
          load_hazard = 1'b1;
        end else begin
          sel         = SEL_W'(i + 1);
          load_hazard = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding / load-use hazard unit: shadow tag pipe, bypass selects, stall and
// saturating stall counter.
module fwd_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 3,
  parameter int NUM_FWD    = 3,
  parameter int LOAD_STAGE = 1,
  parameter int CNT_W      = 16
) (
  input logic              clk,
  input logic              rst,
  fwd_hazard_unit_if.slave hz
);

  localparam int SEL_W = $clog2(NUM_FWD + 1);

  hazard_tag_t [NUM_FWD-1:0] tag_reg;
  logic [CNT_W-1:0]          cnt_reg;
  logic                      haz_a;
  logic                      haz_b;
  logic                      stall_int;

  fwd_prio_match #(
    .REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)
  ) u_match_a (
    .tags        (tag_reg),
    .src         (hz.id_src_a),
    .use_src     (hz.id_valid & hz.id_use_a),
    .sel         (hz.fwd_sel_a),
    .load_hazard (haz_a)
  );

  fwd_prio_match #(
    .REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)
  ) u_match_b (
    .tags        (tag_reg),
    .src         (hz.id_src_b),
    .use_src     (hz.id_valid & hz.id_use_b),
    .sel         (hz.fwd_sel_b),
    .load_hazard (haz_b)
  );

  // A redirect makes the hazard moot: the dependent instruction is being killed.
  assign stall_int    = (haz_a | haz_b) & ~hz.flush;
  assign hz.stall     = stall_int;
  assign hz.stall_cnt = cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_reg <= '0;
    end else begin
      for (int i = NUM_FWD - 1; i >= 1; i--) begin
        tag_reg[i] <= tag_reg[i-1];
      end
      if (hz.flush) begin
        tag_reg[0] <= '0;
        tag_reg[1] <= '0;
      end else if (stall_int) begin
        tag_reg[0] <= '0;
      end else begin
        tag_reg[0] <= '{v:   hz.id_valid & hz.id_wr,
                        dst: TAG_DST_W'(hz.id_dst),
                        ld:  hz.id_load};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (stall_int && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: a queue-based reference model predicts selects/stall/counter
// for two configurations; a negedge monitor pops and compares.
module tb_fwd_hazard_unit;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst_m = 1'b1;
  logic rst_s = 1'b1;
  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.REG_AW(3), .NUM_FWD(3), .CNT_W(16)) hm ();
  fwd_hazard_unit_if #(.REG_AW(3), .NUM_FWD(4), .CNT_W(8))  hs ();

  fwd_hazard_unit #(.REG_AW(3), .NUM_FWD(3), .LOAD_STAGE(1), .CNT_W(16)) dut_m (
    .clk(clk), .rst(rst_m), .hz(hm));
  fwd_hazard_unit #(.REG_AW(3), .NUM_FWD(4), .LOAD_STAGE(3), .CNT_W(8)) dut_s (
    .clk(clk), .rst(rst_s), .hz(hs));

  typedef struct {
    bit rst; bit valid; int src_a; bit use_a; int src_b; bit use_b;
    int dst; bit wr; bit ld; bit flush;
  } stim_t;
  typedef struct { int sa; int sb; bit st; int cnt; string tag; } exp_t;
  typedef struct { bit v; int dst; bit ld; } mtag_t;

  mtag_t hist_m[$];
  mtag_t hist_s[$];
  int    cnt_m, cnt_s;
  exp_t  q_m[$];
  exp_t  q_s[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  function automatic stim_t ins(bit v, int a, bit ua, int b, bit ub, int d, bit wr, bit ld);
    stim_t s;
    s.rst = 0; s.valid = v; s.src_a = a; s.use_a = ua; s.src_b = b; s.use_b = ub;
    s.dst = d; s.wr = wr; s.ld = ld; s.flush = 0;
    return s;
  endfunction
  function automatic stim_t op_add(int d, int a, int b); return ins(1, a, 1, b, 1, d, 1, 0); endfunction
  function automatic stim_t op_lw(int d, int a);         return ins(1, a, 1, 0, 0, d, 1, 1); endfunction
  function automatic stim_t op_sw(int data, int base);   return ins(1, base, 1, data, 1, 0, 0, 0); endfunction
  function automatic stim_t op_nop();                    return ins(0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic stim_t op_rst();
    stim_t s = op_nop();
    s.rst = 1;
    return s;
  endfunction

  // Youngest in-flight writer of src decides: too-early load -> hazard, else bypass from its slot.
  function automatic void look(input mtag_t h[$], input int ls, input bit en, input int src,
                               output int sel, output bit haz);
    sel = 0; haz = 0;
    if (!en) return;
    foreach (h[i]) begin
      if (h[i].v && h[i].dst == src) begin
        if (h[i].ld && i < ls) haz = 1; else sel = i + 1;
        return;
      end
    end
  endfunction

  task automatic apply(input int inst, input stim_t s);
    if (inst == 0) begin
      hm.id_valid = s.valid; hm.id_src_a = 3'(s.src_a); hm.id_use_a = s.use_a;
      hm.id_src_b = 3'(s.src_b); hm.id_use_b = s.use_b; hm.id_dst = 3'(s.dst);
      hm.id_wr = s.wr; hm.id_load = s.ld; hm.flush = s.flush; rst_m = s.rst;
    end else begin
      hs.id_valid = s.valid; hs.id_src_a = 3'(s.src_a); hs.id_use_a = s.use_a;
      hs.id_src_b = 3'(s.src_b); hs.id_use_b = s.use_b; hs.id_dst = 3'(s.dst);
      hs.id_wr = s.wr; hs.id_load = s.ld; hs.flush = s.flush; rst_s = s.rst;
    end
  endtask

  // One cycle: present s after the edge, push the prediction, advance the model.
  task automatic drive(input int inst, input stim_t s, input string tag, output bit st);
    mtag_t h[$];
    int    cnt, ls, cmax, sa, sb;
    bit    ha, hb;
    exp_t  e;
    @(posedge clk);
    #1;
    apply(inst, s);
    if (inst == 0) begin h = hist_m; cnt = cnt_m; ls = 1; cmax = 65535; end
    else           begin h = hist_s; cnt = cnt_s; ls = 3; cmax = 255;   end
    if (s.rst) begin
      foreach (h[i]) h[i] = '{v: 0, dst: 0, ld: 0};
      cnt = 0;
    end
    look(h, ls, s.valid && s.use_a, s.src_a, sa, ha);
    look(h, ls, s.valid && s.use_b, s.src_b, sb, hb);
    st = (ha || hb) && !s.flush && !s.rst;
    e.sa = sa; e.sb = sb; e.st = st; e.cnt = cnt; e.tag = tag;
    if (inst == 0) q_m.push_back(e); else q_s.push_back(e);
    if (!s.rst) begin
      if (s.flush) h[0].v = 0;
      if (s.flush || st) h.push_front('{v: 0, dst: 0, ld: 0});
      else               h.push_front('{v: s.valid && s.wr, dst: s.dst, ld: s.ld});
      void'(h.pop_back());
      if (st && cnt < cmax) cnt++;
    end
    if (inst == 0) begin hist_m = h; cnt_m = cnt; end
    else           begin hist_s = h; cnt_s = cnt; end
  endtask

  // ID holds an instruction until it is no longer stalled.
  task automatic issue(input int inst, input stim_t s, input string tag);
    bit st;
    int n = 0;
    do begin
      drive(inst, s, tag, st);
      n++;
    end while (st && n < 10);
    if (st) begin
      n_checks++;
      $display("FAIL %s stall_bound stall=1 after %0d cycles, required 0", tag, n);
    end
  endtask

  task automatic chk(input string tag, input string field, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s.%s act=%0d exp=%0d", tag, field, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q_m.size() != 0) begin
      e = q_m.pop_front();
      chk(e.tag, "fwd_sel_a", int'(hm.fwd_sel_a), e.sa);
      chk(e.tag, "fwd_sel_b", int'(hm.fwd_sel_b), e.sb);
      chk(e.tag, "stall", int'(hm.stall), int'(e.st));
      chk(e.tag, "stall_cnt", int'(hm.stall_cnt), e.cnt);
      $display("m %-10s sel_a=%0d sel_b=%0d stall=%0b cnt=%0d", e.tag, hm.fwd_sel_a,
               hm.fwd_sel_b, hm.stall, hm.stall_cnt);
    end
    if (q_s.size() != 0) begin
      e = q_s.pop_front();
      chk(e.tag, "fwd_sel_a", int'(hs.fwd_sel_a), e.sa);
      chk(e.tag, "fwd_sel_b", int'(hs.fwd_sel_b), e.sb);
      chk(e.tag, "stall", int'(hs.stall), int'(e.st));
      chk(e.tag, "stall_cnt", int'(hs.stall_cnt), e.cnt);
    end
  end

  initial begin
    stim_t s;
    bit    st;
    int    n;
    for (int i = 0; i < 3; i++) hist_m.push_back('{v: 0, dst: 0, ld: 0});
    for (int i = 0; i < 4; i++) hist_s.push_back('{v: 0, dst: 0, ld: 0});
    cnt_m = 0; cnt_s = 0;
    apply(0, op_rst());
    apply(1, op_rst());

    issue(0, op_rst(), "reset");
    issue(0, op_rst(), "reset");
    // back-to-back ALU dependency
    issue(0, op_add(1, 2, 3), "t1_prod");
    issue(0, op_add(4, 1, 1), "t1_cons");
    for (int k = 0; k < 3; k++) issue(0, op_nop(), "nop");
    // store data dependency at distance 2, 3, 4
    for (int gap = 1; gap <= 3; gap++) begin
      issue(0, op_add(1, 2, 3), "t2_prod");
      for (int k = 0; k < gap; k++) issue(0, op_nop(), "t2_nop");
      issue(0, op_sw(1, 5), "t2_sw");
      for (int k = 0; k < 3; k++) issue(0, op_nop(), "nop");
    end
    // youngest producer wins
    issue(0, op_add(1, 2, 3), "t3_old");
    issue(0, op_add(1, 4, 5), "t3_young");
    issue(0, op_add(6, 1, 0), "t3_cons");
    // load-use stall
    issue(0, op_lw(2, 0), "t4_lw");
    issue(0, op_add(3, 2, 4), "t4_use");
    issue(0, op_nop(), "t4_after");
    for (int k = 0; k < 3; k++) issue(0, op_nop(), "nop");
    // flush on the would-stall cycle kills ID and EX
    issue(0, op_lw(2, 0), "t5_lw");
    s = op_add(3, 2, 4); s.flush = 1;
    issue(0, s, "t5_flush");
    issue(0, op_add(5, 2, 2), "t5_post");
    // R7 is an ordinary register here
    issue(0, op_add(7, 1, 2), "r7_prod");
    issue(0, op_add(0, 7, 7), "r7_cons");

    // randomized traffic; a stalled instruction is re-presented
    s = op_nop();
    st = 0;
    for (int k = 0; k < 400; k++) begin
      if (!st) begin
        s = ins(1'($urandom_range(0, 5) != 0), $urandom_range(0, 3), 1'($urandom),
                $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3), 1'($urandom),
                1'($urandom_range(0, 2) == 0));
      end
      s.flush = ($urandom_range(0, 7) == 0);
      s.rst   = ($urandom_range(0, 79) == 0);
      drive(0, s, "rand", st);
    end

    // deep-load config: sustained stalls to saturate the counter, then reset mid-stall
    issue(1, op_rst(), "s_reset");
    issue(1, op_rst(), "s_reset");
    drive(1, op_lw(2, 0), "s_lw0", st);
    for (int k = 0; k < 360; k++) drive(1, op_lw(2, 2), "s_sat", st);
    n = 0;
    while (!st && n < 8) begin
      drive(1, op_lw(2, 2), "s_sat", st);
      n++;
    end
    if (!st) begin
      n_checks++;
      $display("FAIL s_prestall stall=0, required 1 before reset");
    end
    drive(1, op_rst(), "s_rst_mid", st);
    issue(1, op_lw(2, 2), "s_post");
    issue(1, op_nop(), "s_post");

    repeat (2) @(negedge clk);
    if (q_m.size() != 0 || q_s.size() != 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d, required 0", q_m.size() + q_s.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
